// File: rtl/rf_write_scheduler.sv
// Write-back buffer feeding the two register-file write ports, with a pending-write scoreboard.
// Latency: entry accepted at edge k is offered on a write port in cycle k+1 and commits at edge k+1 when drain_en.
// Backpressure: in_ready drops when fewer than two free entries remain; optional RF_WSCHED_FWD_EN adds a bypass read port.
module rf_write_scheduler #(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid0,
   input  logic [2:0]                   in_dest0,
   input  logic [31:0]                  in_data0,
   input  logic                         in_valid1,
   input  logic [2:0]                   in_dest1,
   input  logic [31:0]                  in_data1,
   output logic                         in_ready,
   input  logic                         drain_en,
   output logic                         regWrite1,
   output logic [2:0]                   destReg1,
   output logic [31:0]                  writeData1,
   output logic                         regWrite2,
   output logic [2:0]                   destReg2,
   output logic [31:0]                  writeData2,
   output logic [7:0]                   pending,
`ifdef RF_WSCHED_FWD_EN
   input  logic [2:0]                   fwd_sel,
   output logic                         fwd_hit,
   output logic [31:0]                  fwd_data,
`endif
   output logic [$clog2(DEPTH):0]       count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   // Room for a full pair means occupancy at most DEPTH-2.
   localparam logic [CW-1:0] MAX_FILL = CW'(DEPTH - 2);

   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [2:0]    dest_q [DEPTH];
   logic [2:0]    dest_d [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [31:0]   data_d [DEPTH];

   logic [AW-1:0] rd_ptr_p1;
   logic [CW-1:0] enq_n, deq_n;

   assign rd_ptr_p1 = rd_ptr_q + AW'(1);
   assign count     = count_q;

   // Head-of-queue write ports; everything is forced quiet while reset is held.
   always_comb begin
      in_ready   = !reset && (count_q <= MAX_FILL);
      regWrite1  = !reset && drain_en && (count_q >= CW'(1));
      regWrite2  = !reset && drain_en && (count_q >= CW'(2));
      destReg1   = regWrite1 ? dest_q[rd_ptr_q]  : 3'd0;
      writeData1 = regWrite1 ? data_q[rd_ptr_q]  : 32'd0;
      destReg2   = regWrite2 ? dest_q[rd_ptr_p1] : 3'd0;
      writeData2 = regWrite2 ? data_q[rd_ptr_p1] : 32'd0;
   end

   // Scoreboard: one bit per register with a buffered, uncommitted write.
   always_comb begin
      pending = 8'd0;
      if (!reset) begin
         for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count_q)
               pending[dest_q[rd_ptr_q + AW'(k)]] = 1'b1;
         end
      end
   end

`ifdef RF_WSCHED_FWD_EN
   // Bypass: walk oldest to youngest so the youngest matching entry wins.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = 32'd0;
      if (!reset) begin
         for (int k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < count_q) && (dest_q[rd_ptr_q + AW'(k)] == fwd_sel)) begin
               fwd_hit  = 1'b1;
               fwd_data = data_q[rd_ptr_q + AW'(k)];
            end
         end
      end
   end
`endif

   // Next-state: enqueue packs valid lanes contiguously from wr_ptr, dequeue pops what the ports wrote.
   always_comb begin
      dest_d   = dest_q;
      data_d   = data_q;
      wr_ptr_d = wr_ptr_q;
      enq_n    = CW'(0);
      deq_n    = CW'(regWrite1) + CW'(regWrite2);
      if (in_ready) begin
         if (in_valid0 && in_valid1) begin
            dest_d[wr_ptr_q]          = in_dest0;
            data_d[wr_ptr_q]          = in_data0;
            dest_d[wr_ptr_q + AW'(1)] = in_dest1;
            data_d[wr_ptr_q + AW'(1)] = in_data1;
            wr_ptr_d                  = wr_ptr_q + AW'(2);
            enq_n                     = CW'(2);
         end else if (in_valid0) begin
            dest_d[wr_ptr_q] = in_dest0;
            data_d[wr_ptr_q] = in_data0;
            wr_ptr_d         = wr_ptr_q + AW'(1);
            enq_n            = CW'(1);
         end else if (in_valid1) begin
            dest_d[wr_ptr_q] = in_dest1;
            data_d[wr_ptr_q] = in_data1;
            wr_ptr_d         = wr_ptr_q + AW'(1);
            enq_n            = CW'(1);
         end
      end
      rd_ptr_d = rd_ptr_q + AW'(deq_n);
      count_d  = count_q + enq_n - deq_n;
   end

   // Control state; reset discards all buffered entries.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage needs no reset: occupancy is defined solely by count_q.
   always_ff @(posedge clk) begin
      dest_q <= dest_d;
      data_q <= data_d;
   end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed bench for rf_write_scheduler with a small register-file model on the write ports.
// Inputs change 2ns after each rising edge; outputs are checked 1ns later, far from the edge.
// Each comparison is an immediate assertion that counts and reports its own failure.
module tb_rf_write_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid0, in_valid1;
   logic [2:0]  in_dest0, in_dest1;
   logic [31:0] in_data0, in_data1;
   logic        in_ready;
   logic        drain_en;
   logic        regWrite1, regWrite2;
   logic [2:0]  destReg1, destReg2;
   logic [31:0] writeData1, writeData2;
   logic [7:0]  pending;
   logic [2:0]  count;
`ifdef RF_WSCHED_FWD_EN
   logic [2:0]  fwd_sel;
   logic        fwd_hit;
   logic [31:0] fwd_data;
`endif

   int checks = 0;
   int errors = 0;

   logic [31:0] rf [8];
   int          wr_events = 0;

   always #5 clk = ~clk;

   rf_write_scheduler #(.DEPTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid0  (in_valid0),
      .in_dest0   (in_dest0),
      .in_data0   (in_data0),
      .in_valid1  (in_valid1),
      .in_dest1   (in_dest1),
      .in_data1   (in_data1),
      .in_ready   (in_ready),
      .drain_en   (drain_en),
      .regWrite1  (regWrite1),
      .destReg1   (destReg1),
      .writeData1 (writeData1),
      .regWrite2  (regWrite2),
      .destReg2   (destReg2),
      .writeData2 (writeData2),
      .pending    (pending),
`ifdef RF_WSCHED_FWD_EN
      .fwd_sel    (fwd_sel),
      .fwd_hit    (fwd_hit),
      .fwd_data   (fwd_data),
`endif
      .count      (count)
   );

   // Register file model: port 2 is applied last so it wins a same-destination pair.
   always @(posedge clk) begin
      if (regWrite1) begin
         rf[destReg1] <= writeData1;
         wr_events    <= wr_events + 1;
      end
      if (regWrite2) begin
         rf[destReg2] <= writeData2;
         wr_events    <= wr_events + 1 + (regWrite1 ? 1 : 0);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      in_valid0 = 1'b0; in_dest0 = 3'd0; in_data0 = 32'd0;
      in_valid1 = 1'b0; in_dest1 = 3'd0; in_data1 = 32'd0;
   endtask

   task automatic set_pair(input logic v0, input logic [2:0] d0, input logic [31:0] x0,
                           input logic v1, input logic [2:0] d1, input logic [31:0] x1);
      in_valid0 = v0; in_dest0 = d0; in_data0 = x0;
      in_valid1 = v1; in_dest1 = d1; in_data1 = x1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ev_snap;
      for (int r = 0; r < 8; r++) rf[r] = 32'd0;
      reset    = 1'b1;
      drain_en = 1'b1;
      idle_inputs();
`ifdef RF_WSCHED_FWD_EN
      fwd_sel = 3'd0;
`endif

      // Reset held for two cycles, then released.
      tick();
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_regwrite1", regWrite1, 0);
      chk("rst_pending", pending, 8'h00);
      tick();
      reset    = 1'b0;
      drain_en = 1'b0;
      #1;
      chk("idle_count", count, 0);
      chk("idle_pending", pending, 8'h00);
      chk("idle_regwrite1", regWrite1, 0);
      chk("idle_regwrite2", regWrite2, 0);
      chk("idle_in_ready", in_ready, 1);

      // Dual enqueue with drain held off, then one drain cycle empties it.
      set_pair(1, 3'd2, 32'h22, 1, 3'd3, 32'h33);
      tick();
      idle_inputs();
      #1;
      chk("dual_pending", pending, 8'h0C);
      chk("dual_count", count, 2);
      chk("dual_nodrain_rw1", regWrite1, 0);
      drain_en = 1'b1;
      #1;
      chk("dual_rw1", regWrite1, 1);
      chk("dual_dest1", destReg1, 2);
      chk("dual_data1", writeData1, 32'h22);
      chk("dual_rw2", regWrite2, 1);
      chk("dual_dest2", destReg2, 3);
      chk("dual_data2", writeData2, 32'h33);
      tick();
      drain_en = 1'b0;
      #1;
      chk("dual_after_count", count, 0);
      chk("dual_after_pending", pending, 8'h00);
      chk("dual_rf_r2", rf[2], 32'h22);
      chk("dual_rf_r3", rf[3], 32'h33);

      // Same destination pair: younger value must survive.
      drain_en = 1'b1;
      set_pair(1, 3'd5, 32'hA, 1, 3'd5, 32'hB);
      tick();
      idle_inputs();
      #1;
      chk("same_pending", pending, 8'h20);
      chk("same_dest1", destReg1, 5);
      chk("same_dest2", destReg2, 5);
      chk("same_data1", writeData1, 32'hA);
      chk("same_data2", writeData2, 32'hB);
      tick();
      #1;
      chk("same_count", count, 0);
      chk("same_rf_r5", rf[5], 32'hB);

      // Fill to DEPTH and hold a third pair that must not be accepted.
      drain_en = 1'b0;
      set_pair(1, 3'd1, 32'h11, 1, 3'd2, 32'h12);
      tick();
      set_pair(1, 3'd3, 32'h13, 1, 3'd4, 32'h14);
      #1;
      chk("fill_half_ready", in_ready, 1);
      tick();
      set_pair(1, 3'd6, 32'h16, 1, 3'd7, 32'h17);
      #1;
      chk("full_count", count, 4);
      chk("full_in_ready", in_ready, 0);
      chk("full_pending", pending, 8'h1E);
      tick();
      #1;
      chk("full_held_count", count, 4);
      chk("full_held_pending", pending, 8'h1E);
      idle_inputs();
      drain_en = 1'b1;
      #1;
      chk("drain_a_dest1", destReg1, 1);
      chk("drain_a_data1", writeData1, 32'h11);
      chk("drain_a_dest2", destReg2, 2);
      chk("drain_a_data2", writeData2, 32'h12);
      chk("drain_a_in_ready", in_ready, 0);
      tick();
      #1;
      chk("drain_b_count", count, 2);
      chk("drain_b_in_ready", in_ready, 1);
      chk("drain_b_dest1", destReg1, 3);
      chk("drain_b_data2", writeData2, 32'h14);
      tick();
      drain_en = 1'b0;
      #1;
      chk("drain_c_count", count, 0);
      chk("drain_c_rf_r4", rf[4], 32'h14);

      // Lane 1 alone lands at the head and drains on port 1.
      set_pair(0, 3'd0, 32'h0, 1, 3'd7, 32'h77);
      tick();
      idle_inputs();
      #1;
      chk("l1_count", count, 1);
      chk("l1_pending", pending, 8'h80);
      drain_en = 1'b1;
      #1;
      chk("l1_rw1", regWrite1, 1);
      chk("l1_dest1", destReg1, 7);
      chk("l1_data1", writeData1, 32'h77);
      chk("l1_rw2", regWrite2, 0);
      chk("l1_dest2", destReg2, 0);
      chk("l1_data2", writeData2, 32'h0);
      tick();
      drain_en = 1'b0;
      #1;
      chk("l1_after_count", count, 0);

      // Three entries: drain two, then one.
      set_pair(1, 3'd1, 32'hA1, 1, 3'd2, 32'hA2);
      tick();
      set_pair(1, 3'd3, 32'hA3, 0, 3'd0, 32'h0);
      tick();
      idle_inputs();
      drain_en = 1'b1;
      #1;
      chk("odd_count3", count, 3);
      chk("odd_a_rw2", regWrite2, 1);
      chk("odd_a_dest2", destReg2, 2);
      tick();
      #1;
      chk("odd_b_count", count, 1);
      chk("odd_b_dest1", destReg1, 3);
      chk("odd_b_data1", writeData1, 32'hA3);
      chk("odd_b_rw2", regWrite2, 0);
      tick();
      drain_en = 1'b0;
      #1;
      chk("odd_c_count", count, 0);
      chk("odd_c_pending", pending, 8'h00);

      // Reset with three entries buffered: nothing may be written.
      set_pair(1, 3'd1, 32'hB1, 1, 3'd2, 32'hB2);
      tick();
      set_pair(1, 3'd6, 32'hB6, 0, 3'd0, 32'h0);
      tick();
      idle_inputs();
      #1;
      chk("mid_count3", count, 3);
      ev_snap  = wr_events;
      reset    = 1'b1;
      drain_en = 1'b1;
      #1;
      chk("mid_rst_rw1", regWrite1, 0);
      chk("mid_rst_rw2", regWrite2, 0);
      chk("mid_rst_dest1", destReg1, 0);
      chk("mid_rst_data1", writeData1, 32'h0);
      chk("mid_rst_pending", pending, 8'h00);
      chk("mid_rst_in_ready", in_ready, 0);
      tick();
      reset = 1'b0;
      #1;
      chk("mid_post_count", count, 0);
      chk("mid_post_pending", pending, 8'h00);
      chk("mid_post_rw1", regWrite1, 0);
      chk("mid_post_in_ready", in_ready, 1);
      tick();
      drain_en = 1'b0;
      #1;
      chk("mid_no_writes", wr_events, ev_snap);
      chk("mid_rf_r6", rf[6], 32'h0);

`ifdef RF_WSCHED_FWD_EN
      // Bypass returns the youngest matching entry.
      set_pair(1, 3'd4, 32'h1, 1, 3'd4, 32'h2);
      tick();
      idle_inputs();
      fwd_sel = 3'd4;
      #1;
      chk("fwd_hit", fwd_hit, 1);
      chk("fwd_data", fwd_data, 32'h2);
      fwd_sel = 3'd3;
      #1;
      chk("fwd_miss_hit", fwd_hit, 0);
      chk("fwd_miss_data", fwd_data, 32'h0);
      reset = 1'b1;
      fwd_sel = 3'd4;
      #1;
      chk("fwd_rst_hit", fwd_hit, 0);
      chk("fwd_rst_data", fwd_data, 32'h0);
      tick();
      reset = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
